instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage: holds the program counter, reads 32-bit instruction words from instruction memory through a req/ack handshake, and presents each word to the decoder stage as `instr` with a one-cycle `enable_I` strobe. The stage sits directly upstream of the decoder. It accepts branch/jump redirects and downstream stalls, and guarantees that no word fetched before a redirect ever reaches the decoder.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word-aligned.
- `clk`  in  1: single clock. Everything is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `mem_req`  out  1: memory read request.
- `mem_addr`  out  32: byte address of the request. Always word-aligned.
- `mem_ack`  in  1: read complete. `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: instruction word.
- `stall`  in  1: downstream cannot accept a new instruction.
- `redirect`  in  1: load a new PC (branch/jump taken).
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored (forced to 0).
- `instr`  out  32: fetched instruction, registered.
- `enable_I`  out  1: one-cycle strobe. `instr` and `pc_out` are new and valid.
- `pc_out`  out  32: address of the word on `instr`.

## Operation
- States:
  - IDLE: no request.
  - FETCH: request outstanding at `pc`.
  - HOLD: fetched word buffered, waiting for `stall` to drop.
  - DRAIN: stale request outstanding after a redirect.
- `mem_req` = 1 in FETCH and DRAIN, 0 otherwise. `mem_addr` = `pc`.
- `mem_req` and `mem_addr` stay stable until `mem_ack`. A request is never withdrawn before it is acknowledged.
- Reset puts the block in IDLE with:
  - `pc` = `RESET_PC`, `instr` = 0, `pc_out` = 0, `enable_I` = 0, hold buffer = 0.
- IDLE -> FETCH, unconditionally.
- FETCH, `mem_ack` = 1, no `redirect`, `stall` = 0:
  - `instr` <= `mem_rdata`, `pc_out` <= `pc`, `enable_I` <= 1.
  - `pc` <= `pc` + 4. Stay in FETCH.
- FETCH, `mem_ack` = 1, no `redirect`, `stall` = 1:
  - Buffer <= `mem_rdata`, `pc` <= `pc` + 4, go to HOLD.
- FETCH, `mem_ack` = 0: stay in FETCH. `stall` has no effect in this case.
- HOLD, `stall` = 0:
  - `instr` <= buffer, `pc_out` <= `pc` − 4, `enable_I` <= 1. Go to FETCH.
- HOLD, `stall` = 1: stay in HOLD, `enable_I` = 0.
- `redirect` = 1 (priority over `stall` and `mem_ack`; only `reset` is higher):
  - `pc` <= {`redirect_pc`[31:2], 2'b00}. Any buffered word is discarded. `enable_I` <= 0.
  - From FETCH with `mem_ack` = 0: go to DRAIN.
  - From FETCH with `mem_ack` = 1, or from IDLE/HOLD: go to FETCH.
  - From DRAIN: stay in DRAIN with the new `pc` as the target.
- DRAIN:
  - `mem_addr` keeps the old address until ack. An internal `stale_addr` register holds it.
  - On `mem_ack`, data is discarded and the state goes to FETCH at `pc`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- `instr` and `pc_out` hold their last value while `enable_I` = 0.

## Timing
- `enable_I` is registered. It asserts the cycle after the `mem_ack` cycle and lasts exactly one cycle.
- With zero-wait memory (`mem_ack` in the same cycle as `mem_req`), throughput is 1 instruction per cycle and `enable_I` stays high continuously.
- First request: `mem_req` rises 2 cycles after the last cycle with `reset` = 1 (the IDLE cycle comes first).
- Redirect latency, zero-wait memory: redirect in cycle N gives a request at the target in N+1 and `enable_I` for the target in N+2.
- Redirect while a request is outstanding: the DRAIN cost equals the remaining memory wait, plus 1 cycle.
- HOLD release: `stall` falls in cycle N gives `enable_I` in N+1 and a new request in N+1.
- `reset` in any state overrides everything in that cycle. Mid-operation, `enable_I` = 0 next cycle and pending data is dropped. Memory must tolerate an abandoned request on reset.

## Test plan
- Reset then zero-wait memory returning 32'h3401_0001, 32'h0001_1019, 32'h0800_0020 at addresses 0, 4, 8:
  - `mem_req` rises 2 cycles after reset.
  - `enable_I` is high on 3 consecutive cycles.
  - `instr`/`pc_out` = those words / 0, 4, 8.
- Memory with 3 wait cycles: `mem_addr` is stable for 4 cycles per fetch. `enable_I` pulses once every 4 cycles, each pulse exactly 1 cycle wide.
- `stall` = 1 during the ack of address 8 for 5 cycles:
  - No `enable_I` while stalled.
  - After `stall` falls, `instr` = 32'h0800_0020 and `pc_out` = 8.
  - Next request is to 12. No word is lost or duplicated.
- `redirect` with `redirect_pc` = 32'h0000_0083 while the request to 4 is waiting:
  - The request to 4 completes and its data is dropped.
  - Next `mem_addr` = 32'h0000_0080.
  - First `enable_I` carries `pc_out` = 32'h80.
- `redirect` and `stall` asserted together in the ack cycle: the word is discarded, the state is not HOLD, and the next `mem_addr` is the redirect target.
- `RESET_PC` = 32'hFFFF_FFFC: second fetch is at address 0 (wrap). Asserting `reset` mid-stream returns `mem_addr` to 32'hFFFF_FFFC with `enable_I` = 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: request/acknowledge handshake between the
// fetch stage (master) and instruction memory (slave).
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads words through the memory
// handshake and hands each one to the decoder with a one-cycle enable_I.
// Redirects flush everything in flight; a request that is still outstanding
// when a redirect arrives is allowed to finish (DRAIN) and its data dropped.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        mem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          instr,
    output logic                 enable_I,
    output logic [31:0]          pc_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] hold_buf_q;
    logic [31:0] stale_addr_q;

    logic [31:0] redirect_target;
    logic        deliver_direct;
    logic        capture_to_hold;
    logic        release_hold;
    logic        start_drain;

    // Byte-offset bits of a redirect target are meaningless for word fetches.
    assign redirect_target = redirect_pc & WORD_MASK;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every register sees the
        // pre-edge values of the others, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect outranks stall and ack in every state.
    always_comb begin
        // NOTE: a default for every always_comb output keeps any branch that
        // forgets an assignment from turning into a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    state_d = mem.mem_ack ? FETCH : DRAIN;
                end else if (mem.mem_ack && stall) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // The stale request finishing frees the port, whether or not a
                // further redirect arrives in the same cycle.
                if (mem.mem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath-control decode from the current state.
    always_comb begin
        mem.mem_req     = 1'b0;
        mem.mem_addr    = pc_q;
        deliver_direct  = 1'b0;
        capture_to_hold = 1'b0;
        release_hold    = 1'b0;
        start_drain     = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem.mem_req = 1'b0;
            end
            FETCH: begin
                mem.mem_req     = 1'b1;
                mem.mem_addr    = pc_q;
                deliver_direct  = mem.mem_ack && !redirect && !stall;
                capture_to_hold = mem.mem_ack && !redirect &&  stall;
                start_drain     = !mem.mem_ack && redirect;
            end
            HOLD: begin
                release_hold = !redirect && !stall;
            end
            DRAIN: begin
                // The abandoned request keeps its original address until acked.
                mem.mem_req  = 1'b1;
                mem.mem_addr = stale_addr_q;
            end
            default: begin
                mem.mem_req = 1'b0;
            end
        endcase
    end

    // Datapath: PC, hold buffer, stale address and the decoder-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC & WORD_MASK;
            // NOTE: the hold buffer is a single word, so it is reset along with
            // the rest of the state; only true memory arrays skip reset.
            hold_buf_q   <= '0;
            stale_addr_q <= '0;
            instr        <= '0;
            pc_out       <= '0;
            enable_I     <= 1'b0;
        end else begin
            enable_I <= 1'b0;
            if (redirect) begin
                pc_q       <= redirect_target;
                hold_buf_q <= '0;
                if (start_drain) begin
                    stale_addr_q <= pc_q;
                end
            end else begin
                if (deliver_direct) begin
                    instr    <= mem.mem_rdata;
                    pc_out   <= pc_q;
                    enable_I <= 1'b1;
                    pc_q     <= pc_q + 32'd4;
                end
                if (capture_to_hold) begin
                    hold_buf_q <= mem.mem_rdata;
                    pc_q       <= pc_q + 32'd4;
                end
                if (release_hold) begin
                    // pc already advanced past the buffered word when it was captured.
                    instr    <= hold_buf_q;
                    pc_out   <= pc_q - 32'd4;
                    enable_I <= 1'b1;
                end
            end
        end
    end

    // A request is never withdrawn or retargeted before it is acknowledged.
    a_req_held : assert property (@(posedge clk) disable iff (reset)
        (mem.mem_req && !mem.mem_ack) |=> (mem.mem_req && $stable(mem.mem_addr)));

    // Requests are always word-aligned.
    a_addr_aligned : assert property (@(posedge clk) disable iff (reset)
        mem.mem_req |-> (mem.mem_addr[1:0] == 2'b00));

endmodule
